// File: rtl/warp_switcher_pkg.sv
// Shared types for the warp switcher: core pipeline states, switcher FSM states,
// and the eligibility rule used when choosing the next warp.
package warp_switcher_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } corestate_t;

  typedef enum logic [2:0] {
    SW_IDLE    = 3'd0,
    SW_SELECT  = 3'd1,
    SW_RESTORE = 3'd2,
    SW_RUN     = 3'd3,
    SW_DONE    = 3'd4
  } switcher_state_t;

  // A warp can run if it is launched, not finished, and not blocked on memory.
  function automatic logic warp_eligible(input logic active, input corestate_t st,
                                         input logic memReady);
    return active && (st != CORE_DONE) && ((st != CORE_WAIT) || memReady);
  endfunction

endpackage

// File: rtl/warp_switcher_picker.sv
// Round-robin picker: finds the first eligible warp after the base index,
// checking the base itself last. Purely combinational.
module rr_warp_picker #(
  parameter int NUM_WARPS  = 2,
  parameter int WARP_IDX_W = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0]  i_eligible,
  input  logic [WARP_IDX_W-1:0] i_base,
  output logic                  o_found,
  output logic [WARP_IDX_W-1:0] o_index
);

  // Walk base+1 .. base+NUM_WARPS; the wrap is an explicit compare so odd warp counts work.
  always_comb begin
    logic [WARP_IDX_W-1:0] w_probe;
    o_found = 1'b0;
    o_index = '0;
    w_probe = i_base;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      if (w_probe == WARP_IDX_W'(NUM_WARPS - 1)) begin
        w_probe = '0;
      end else begin
        w_probe = w_probe + WARP_IDX_W'(1);
      end
      if (!o_found && i_eligible[w_probe]) begin
        o_found = 1'b1;
        o_index = w_probe;
      end
    end
  end

endmodule

// File: rtl/warp_switcher.sv
// Warp switcher: picks the next warp on scheduler request, drives warp_select
// back to the context store and replays the chosen warp's context into the core.
module warp_switcher
  import warp_switcher_pkg::*;
#(
  parameter int NUM_WARPS   = 2,
  parameter int WARP_IDX_W  = $clog2(NUM_WARPS),
  parameter int STALL_CNT_W = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic       [NUM_WARPS-1:0]      i_warp_active,
  input  logic       [NUM_WARPS-1:0][7:0] i_ctx_pc,
  input  corestate_t [NUM_WARPS-1:0]      i_ctx_state,
  input  logic       [NUM_WARPS-1:0]      i_ctx_mem_rd,
  input  logic       [NUM_WARPS-1:0]      i_ctx_mem_wr,
  input  logic       [NUM_WARPS-1:0]      i_mem_ready,
  input  logic                            i_switch_req,
  output logic       [WARP_IDX_W-1:0]     o_warp_select,
  output logic                            o_restore_valid,
  output logic       [7:0]                o_restore_pc,
  output corestate_t                      o_restore_state,
  output logic                            o_restore_mem_rd,
  output logic                            o_restore_mem_wr,
  output logic                            o_busy,
  output logic                            o_all_done,
  output logic       [STALL_CNT_W-1:0]    o_stall_cycles
);

  switcher_state_t         r_state;
  logic [WARP_IDX_W-1:0]   r_warpSelect;
  logic [WARP_IDX_W-1:0]   r_searchBase;
  logic                    r_restoreValid;
  logic [7:0]              r_restorePc;
  corestate_t              r_restoreState;
  logic                    r_restoreMemRd;
  logic                    r_restoreMemWr;
  logic                    r_busy;
  logic                    r_allDone;
  logic [STALL_CNT_W-1:0]  r_stallCycles;

  logic [NUM_WARPS-1:0]    w_eligible;
  logic                    w_allFinished;
  logic                    w_found;
  logic [WARP_IDX_W-1:0]   w_pickIdx;

  // Per-warp eligibility, and whether every launched warp has finished.
  always_comb begin
    w_eligible    = '0;
    w_allFinished = 1'b1;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_eligible[w] = warp_eligible(i_warp_active[w], i_ctx_state[w], i_mem_ready[w]);
      if (i_warp_active[w] && (i_ctx_state[w] != CORE_DONE)) begin
        w_allFinished = 1'b0;
      end
    end
  end

  rr_warp_picker #(
    .NUM_WARPS (NUM_WARPS),
    .WARP_IDX_W(WARP_IDX_W)
  ) u_picker (
    .i_eligible(w_eligible),
    .i_base    (r_searchBase),
    .o_found   (w_found),
    .o_index   (w_pickIdx)
  );

  // Switcher FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= SW_IDLE;
      r_warpSelect   <= '0;
      r_searchBase   <= '0;
      r_restoreValid <= 1'b0;
      r_restorePc    <= '0;
      r_restoreState <= CORE_IDLE;
      r_restoreMemRd <= 1'b0;
      r_restoreMemWr <= 1'b0;
      r_busy         <= 1'b0;
      r_allDone      <= 1'b0;
      r_stallCycles  <= '0;
    end else begin
      case (r_state)
        SW_IDLE: begin
          if (i_start) begin
            r_searchBase <= WARP_IDX_W'(NUM_WARPS - 1);
            r_busy       <= 1'b1;
            r_state      <= SW_SELECT;
          end
        end
        SW_SELECT: begin
          if (w_found) begin
            r_warpSelect   <= w_pickIdx;
            r_restorePc    <= i_ctx_pc[w_pickIdx];
            r_restoreState <= (i_ctx_state[w_pickIdx] == CORE_WAIT && i_mem_ready[w_pickIdx])
                              ? CORE_EXECUTE : i_ctx_state[w_pickIdx];
            r_restoreMemRd <= i_ctx_mem_rd[w_pickIdx];
            r_restoreMemWr <= i_ctx_mem_wr[w_pickIdx];
            r_restoreValid <= 1'b1;
            r_state        <= SW_RESTORE;
          end else if (w_allFinished) begin
            r_allDone <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= SW_DONE;
          end else if (r_stallCycles != '1) begin
            r_stallCycles <= r_stallCycles + STALL_CNT_W'(1);
          end
        end
        SW_RESTORE: begin
          r_restoreValid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= SW_RUN;
        end
        SW_RUN: begin
          if (i_switch_req) begin
            r_searchBase <= r_warpSelect;
            r_busy       <= 1'b1;
            r_state      <= SW_SELECT;
          end
        end
        SW_DONE: begin
          r_state <= SW_DONE;
        end
        default: begin
          r_state <= SW_IDLE;
        end
      endcase
    end
  end

  assign o_warp_select    = r_warpSelect;
  assign o_restore_valid  = r_restoreValid;
  assign o_restore_pc     = r_restorePc;
  assign o_restore_state  = r_restoreState;
  assign o_restore_mem_rd = r_restoreMemRd;
  assign o_restore_mem_wr = r_restoreMemWr;
  assign o_busy           = r_busy;
  assign o_all_done       = r_allDone;
  assign o_stall_cycles   = r_stallCycles;

endmodule

// File: tb/tb_warp_switcher.sv
// Testbench for warp_switcher: directed scenarios on a 2-warp instance and
// randomized switching on a 3-warp instance against a round-robin model.
module tb_warp_switcher;
  import warp_switcher_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  // Two-warp instance
  logic             start2, switchReq2;
  logic [1:0]       active2, memRd2, memWr2, memReady2;
  logic [1:0][7:0]  pc2;
  corestate_t [1:0] state2;
  logic [0:0]       sel2;
  logic             valid2, restoreRd2, restoreWr2, busy2, allDone2;
  logic [7:0]       restorePc2;
  corestate_t       restoreState2;
  logic [15:0]      stall2;

  // Three-warp instance
  logic             start3, switchReq3;
  logic [2:0]       active3, memRd3, memWr3, memReady3;
  logic [2:0][7:0]  pc3;
  corestate_t [2:0] state3;
  logic [1:0]       sel3;
  logic             valid3, restoreRd3, restoreWr3, busy3, allDone3;
  logic [7:0]       restorePc3;
  corestate_t       restoreState3;
  logic [15:0]      stall3;

  always #5 clk = ~clk;

  warp_switcher #(.NUM_WARPS(2)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_start(start2), .i_warp_active(active2),
    .i_ctx_pc(pc2), .i_ctx_state(state2), .i_ctx_mem_rd(memRd2), .i_ctx_mem_wr(memWr2),
    .i_mem_ready(memReady2), .i_switch_req(switchReq2), .o_warp_select(sel2),
    .o_restore_valid(valid2), .o_restore_pc(restorePc2), .o_restore_state(restoreState2),
    .o_restore_mem_rd(restoreRd2), .o_restore_mem_wr(restoreWr2), .o_busy(busy2),
    .o_all_done(allDone2), .o_stall_cycles(stall2)
  );

  warp_switcher #(.NUM_WARPS(3)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start3), .i_warp_active(active3),
    .i_ctx_pc(pc3), .i_ctx_state(state3), .i_ctx_mem_rd(memRd3), .i_ctx_mem_wr(memWr3),
    .i_mem_ready(memReady3), .i_switch_req(switchReq3), .o_warp_select(sel3),
    .o_restore_valid(valid3), .o_restore_pc(restorePc3), .o_restore_state(restoreState3),
    .o_restore_mem_rd(restoreRd3), .o_restore_mem_wr(restoreWr3), .o_busy(busy3),
    .o_all_done(allDone3), .o_stall_cycles(stall3)
  );

  // Advance one core cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: which warps may be scheduled.
  function automatic bit modelEligible(input logic a, input corestate_t s, input logic r);
    return (a == 1'b1) && (s != CORE_DONE) && ((s != CORE_WAIT) || (r == 1'b1));
  endfunction

  task automatic pulseSwitch2();
    switchReq2 = 1'b1;
    tick();
    switchReq2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start2 = 0; switchReq2 = 0; active2 = 0; memRd2 = 0; memWr2 = 0; memReady2 = 0;
    pc2 = '0; state2 = {CORE_IDLE, CORE_IDLE};
    start3 = 0; switchReq3 = 0; active3 = 0; memRd3 = 0; memWr3 = 0; memReady3 = 0;
    pc3 = '0; state3 = {CORE_IDLE, CORE_IDLE, CORE_IDLE};
    tick(); tick();
    reset = 1'b0;
    checks++; if (sel2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel: got %0d want 0", sel2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0d want 0", valid2); end
    checks++; if (restorePc2 !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %0h want 0", restorePc2); end
    checks++; if (restoreState2 !== CORE_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d want %0d", restoreState2, CORE_IDLE); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0d want 0", busy2); end
    checks++; if (allDone2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_alldone: got %0d want 0", allDone2); end
    checks++; if (stall2 !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall: got %0d want 0", stall2); end
    checks++; if (sel3 !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel3: got %0d want 0", sel3); end
  endtask

  task automatic test_start();
    active2 = 2'b11; state2[0] = CORE_FETCH; state2[1] = CORE_FETCH;
    pc2[0] = 8'h00; pc2[1] = 8'h10;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL start_busy: got %0d want 1", busy2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL start_early_valid: got %0d want 0", valid2); end
    tick();
    checks++; if (valid2 !== 1'b1) begin errors++; $display("[TB] FAIL start_valid: got %0d want 1", valid2); end
    checks++; if (sel2 !== 1'b0) begin errors++; $display("[TB] FAIL start_sel: got %0d want 0", sel2); end
    checks++; if (restorePc2 !== 8'h00) begin errors++; $display("[TB] FAIL start_pc: got %0h want 0", restorePc2); end
    checks++; if (restoreState2 !== CORE_FETCH) begin errors++; $display("[TB] FAIL start_state: got %0d want %0d", restoreState2, CORE_FETCH); end
    tick();
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL start_valid_len: got %0d want 0", valid2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL start_busy_end: got %0d want 0", busy2); end
  endtask

  task automatic test_switch();
    state2[0] = CORE_EXECUTE; pc2[0] = 8'h04;
    state2[1] = CORE_UPDATE;  pc2[1] = 8'h14; memRd2 = 2'b10; memWr2 = 2'b00;
    pulseSwitch2();
    checks++; if (sel2 !== 1'b0) begin errors++; $display("[TB] FAIL switch_sel_held: got %0d want 0", sel2); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL switch_busy: got %0d want 1", busy2); end
    tick();
    checks++; if (sel2 !== 1'b1) begin errors++; $display("[TB] FAIL switch_sel: got %0d want 1", sel2); end
    checks++; if (valid2 !== 1'b1) begin errors++; $display("[TB] FAIL switch_valid: got %0d want 1", valid2); end
    checks++; if (restorePc2 !== 8'h14) begin errors++; $display("[TB] FAIL switch_pc: got %0h want 14", restorePc2); end
    checks++; if (restoreState2 !== CORE_UPDATE) begin errors++; $display("[TB] FAIL switch_state: got %0d want %0d", restoreState2, CORE_UPDATE); end
    checks++; if (restoreRd2 !== 1'b1) begin errors++; $display("[TB] FAIL switch_memrd: got %0d want 1", restoreRd2); end
    tick();
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL switch_valid_len: got %0d want 0", valid2); end
  endtask

  task automatic test_stall();
    state2[0] = CORE_WAIT; state2[1] = CORE_WAIT; memReady2 = 2'b00;
    pc2[1] = 8'h3C; memRd2 = 2'b00; memWr2 = 2'b10;
    pulseSwitch2();
    repeat (5) tick();
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy: got %0d want 1", busy2); end
    checks++; if (stall2 !== 16'd5) begin errors++; $display("[TB] FAIL stall_count: got %0d want 5", stall2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL stall_valid: got %0d want 0", valid2); end
    memReady2 = 2'b10;
    tick();
    checks++; if (valid2 !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume_valid: got %0d want 1", valid2); end
    checks++; if (sel2 !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume_sel: got %0d want 1", sel2); end
    checks++; if (restoreState2 !== CORE_EXECUTE) begin errors++; $display("[TB] FAIL stall_resume_state: got %0d want %0d", restoreState2, CORE_EXECUTE); end
    checks++; if (restoreWr2 !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume_memwr: got %0d want 1", restoreWr2); end
    checks++; if (stall2 !== 16'd5) begin errors++; $display("[TB] FAIL stall_count_after: got %0d want 5", stall2); end
    tick();
    memReady2 = 2'b00; memWr2 = 2'b00;
  endtask

  task automatic test_single();
    active2 = 2'b01; state2[0] = CORE_DECODE; pc2[0] = 8'h22; state2[1] = CORE_FETCH;
    pulseSwitch2();
    tick();
    checks++; if (sel2 !== 1'b0) begin errors++; $display("[TB] FAIL single_first_sel: got %0d want 0", sel2); end
    tick();
    pulseSwitch2();
    tick();
    checks++; if (valid2 !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0d want 1", valid2); end
    checks++; if (sel2 !== 1'b0) begin errors++; $display("[TB] FAIL single_sel: got %0d want 0", sel2); end
    checks++; if (restorePc2 !== 8'h22) begin errors++; $display("[TB] FAIL single_pc: got %0h want 22", restorePc2); end
    checks++; if (restoreState2 !== CORE_DECODE) begin errors++; $display("[TB] FAIL single_state: got %0d want %0d", restoreState2, CORE_DECODE); end
    tick();
  endtask

  task automatic test_done();
    active2 = 2'b11; state2[0] = CORE_DONE; state2[1] = CORE_DONE;
    pulseSwitch2();
    tick();
    checks++; if (allDone2 !== 1'b1) begin errors++; $display("[TB] FAIL done_flag: got %0d want 1", allDone2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL done_busy: got %0d want 0", busy2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL done_valid: got %0d want 0", valid2); end
    state2[0] = CORE_FETCH; state2[1] = CORE_FETCH;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    checks++; if (allDone2 !== 1'b1) begin errors++; $display("[TB] FAIL done_held: got %0d want 1", allDone2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL done_start_ignored: got %0d want 0", busy2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL done_no_restore: got %0d want 0", valid2); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; tick(); reset = 1'b0;
    active2 = 2'b11; state2[0] = CORE_FETCH; state2[1] = CORE_FETCH;
    start2 = 1'b1; tick(); start2 = 1'b0;
    tick(); tick();
    // Reset while in SW_SELECT
    switchReq2 = 1'b1; tick(); switchReq2 = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL rstsel_valid: got %0d want 0", valid2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL rstsel_busy: got %0d want 0", busy2); end
    // Reset while in SW_RESTORE on warp 1
    start2 = 1'b1; tick(); start2 = 1'b0;
    tick(); tick();
    pulseSwitch2();
    tick();
    checks++; if (sel2 !== 1'b1) begin errors++; $display("[TB] FAIL rstres_pre_sel: got %0d want 1", sel2); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL rstres_valid: got %0d want 0", valid2); end
    checks++; if (sel2 !== 1'b0) begin errors++; $display("[TB] FAIL rstres_sel: got %0d want 0", sel2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL rstres_busy: got %0d want 0", busy2); end
    start2 = 1'b1; tick(); start2 = 1'b0;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL rstres_idle_start: got %0d want 1", busy2); end
    tick();
    checks++; if (valid2 !== 1'b1) begin errors++; $display("[TB] FAIL rstres_restart_valid: got %0d want 1", valid2); end
    tick();
  endtask

  task automatic test_random();
    int cur;
    int base;
    int expWarp;
    int w;
    bit anyElig;
    corestate_t expState;
    cur = 0;
    for (int iter = 0; iter < 25; iter++) begin
      for (int i = 0; i < 3; i++) begin
        active3[i]   = ($urandom_range(0, 3) != 0);
        state3[i]    = corestate_t'(3'($urandom_range(0, 7)));
        memReady3[i] = 1'($urandom_range(0, 1));
        memRd3[i]    = 1'($urandom_range(0, 1));
        memWr3[i]    = 1'($urandom_range(0, 1));
        pc3[i]       = 8'($urandom_range(0, 255));
      end
      anyElig = 0;
      for (int i = 0; i < 3; i++) if (modelEligible(active3[i], state3[i], memReady3[i])) anyElig = 1;
      if (!anyElig) begin
        w = $urandom_range(0, 2);
        active3[w] = 1'b1;
        state3[w] = CORE_FETCH;
      end
      base = (iter == 0) ? 2 : cur;
      expWarp = -1;
      for (int k = 1; k <= 3; k++) begin
        w = (base + k) % 3;
        if (expWarp < 0 && modelEligible(active3[w], state3[w], memReady3[w])) expWarp = w;
      end
      expState = (state3[expWarp] == CORE_WAIT) ? CORE_EXECUTE : state3[expWarp];
      if (iter == 0) start3 = 1'b1; else switchReq3 = 1'b1;
      tick();
      start3 = 1'b0; switchReq3 = 1'b0;
      checks++; if (busy3 !== 1'b1) begin errors++; $display("[TB] FAIL rand_busy[%0d]: got %0d want 1", iter, busy3); end
      tick();
      checks++; if (valid3 !== 1'b1) begin errors++; $display("[TB] FAIL rand_valid[%0d]: got %0d want 1", iter, valid3); end
      checks++; if (sel3 !== 2'(expWarp)) begin errors++; $display("[TB] FAIL rand_sel[%0d]: got %0d want %0d", iter, sel3, expWarp); end
      checks++; if (restorePc3 !== pc3[expWarp]) begin errors++; $display("[TB] FAIL rand_pc[%0d]: got %0h want %0h", iter, restorePc3, pc3[expWarp]); end
      checks++; if (restoreState3 !== expState) begin errors++; $display("[TB] FAIL rand_state[%0d]: got %0d want %0d", iter, restoreState3, expState); end
      checks++; if ({restoreRd3, restoreWr3} !== {memRd3[expWarp], memWr3[expWarp]}) begin errors++; $display("[TB] FAIL rand_mem[%0d]: got %b%b want %b%b", iter, restoreRd3, restoreWr3, memRd3[expWarp], memWr3[expWarp]); end
      cur = expWarp;
      tick();
      checks++; if (valid3 !== 1'b0) begin errors++; $display("[TB] FAIL rand_valid_len[%0d]: got %0d want 0", iter, valid3); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_start();
    test_switch();
    test_stall();
    test_single();
    test_done();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
